// File: rtl/ms_timer_sched_pkg.sv
// Shared defaults and types for the millisecond timer scheduler.
package ms_timer_pkg;

  localparam int unsigned MS_N_CH  = 4;
  localparam int unsigned MS_CNT_W = 16;

  // Per-channel control flags. period/count live in CNT_W-wide arrays in the
  // top so that the CNT_W parameter can differ from the package default.
  typedef struct packed {
    logic en;
    logic periodic;
    logic pending;
    logic ovf;
  } ch_flags_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } evt_state_t;

endpackage

// File: rtl/ms_timer_sched_rr_arbiter.sv
// Combinational round-robin pick: the search starts at i_last+1 modulo N_CH.
module rr_arbiter #(
  parameter int unsigned N_CH = 4
) (
  input  logic [N_CH-1:0]         i_pend,
  input  logic [$clog2(N_CH)-1:0] i_last,
  output logic [$clog2(N_CH)-1:0] o_gnt,
  output logic                    o_any
);

  localparam int unsigned IDX_W = $clog2(N_CH);

  always_comb begin
    int unsigned v_idx;
    o_gnt = '0;
    o_any = 1'b0;
    v_idx = 0;
    for (int unsigned off = 1; off <= N_CH; off++) begin
      v_idx = (32'(i_last) + off) % N_CH;
      if (!o_any && i_pend[v_idx[IDX_W-1:0]]) begin
        o_any = 1'b1;
        o_gnt = v_idx[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/ms_timer_sched.sv
// Multi-channel ms timer: per-channel one-shot/periodic countdown with
// round-robin event presentation over a valid/ready handshake and overrun flags.
module ms_timer_sched
  import ms_timer_pkg::*;
#(
  parameter int unsigned N_CH  = MS_N_CH,
  parameter int unsigned CNT_W = MS_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tic,
  input  logic                    cfg_we,
  input  logic [$clog2(N_CH)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]        cfg_period,
  input  logic                    cfg_en,
  input  logic                    cfg_periodic,
  output logic                    evt_valid,
  output logic [$clog2(N_CH)-1:0] evt_ch,
  input  logic                    evt_ready,
  output logic [N_CH-1:0]         ovf
);

  localparam int unsigned IDX_W = $clog2(N_CH);

  ch_flags_t        r_flags  [N_CH];
  logic [CNT_W-1:0] r_period [N_CH];
  logic [CNT_W-1:0] r_count  [N_CH];

  evt_state_t       r_state;
  evt_state_t       w_state_nxt;
  logic [IDX_W-1:0] r_evt_ch;
  logic [IDX_W-1:0] r_last;

  logic [N_CH-1:0]  w_pend;
  logic [N_CH-1:0]  w_take;
  logic [IDX_W-1:0] w_gnt;
  logic             w_any;
  logic             w_fire;

  always_comb begin
    w_pend = '0;
    w_take = '0;
    ovf    = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      w_pend[i] = r_flags[i].pending;
      w_take[i] = w_fire && (w_gnt == IDX_W'(i));
      ovf[i]    = r_flags[i].ovf;
    end
  end

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .i_pend (w_pend),
    .i_last (r_last),
    .o_gnt  (w_gnt),
    .o_any  (w_any)
  );

  // A grant and a fresh expiry in the same cycle leave pending set without
  // flagging an overrun: the old event is being taken as the new one arrives.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (rst) begin
        r_flags[i]  <= '0;
        r_period[i] <= '0;
        r_count[i]  <= '0;
      end else if (cfg_we && (cfg_ch == IDX_W'(i))) begin
        r_period[i]           <= cfg_period;
        r_count[i]            <= cfg_period;
        r_flags[i].en         <= cfg_en && (cfg_period != '0);
        r_flags[i].periodic   <= cfg_periodic;
        r_flags[i].pending    <= 1'b0;
        r_flags[i].ovf        <= 1'b0;
      end else begin
        if (w_take[i])
          r_flags[i].pending <= 1'b0;
        if (tic && r_flags[i].en) begin
          if (r_count[i] > CNT_W'(1)) begin
            r_count[i] <= r_count[i] - CNT_W'(1);
          end else if (r_count[i] == CNT_W'(1)) begin
            r_flags[i].pending <= 1'b1;
            if (r_flags[i].pending && !w_take[i])
              r_flags[i].ovf <= 1'b1;
            if (r_flags[i].periodic) begin
              r_count[i] <= r_period[i];
            end else begin
              r_count[i]    <= '0;
              r_flags[i].en <= 1'b0;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fire      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_fire      = 1'b1;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (evt_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_evt_ch <= '0;
      r_last   <= IDX_W'(N_CH - 1);
    end else if (w_fire) begin
      r_evt_ch <= w_gnt;
      r_last   <= w_gnt;
    end
  end

  assign evt_valid = (r_state == ST_HOLD);
  assign evt_ch    = r_evt_ch;

endmodule

// File: tb/tb_ms_timer_sched.sv
// Directed self-checking bench for ms_timer_sched (N_CH=4, CNT_W=16).
module tb_ms_timer_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        tic;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_period;
  logic        cfg_en;
  logic        cfg_periodic;
  logic        evt_valid;
  logic [1:0]  evt_ch;
  logic        evt_ready;
  logic [3:0]  ovf;

  int checks = 0;
  int errors = 0;

  ms_timer_sched #(.N_CH(4), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .tic          (tic),
    .cfg_we       (cfg_we),
    .cfg_ch       (cfg_ch),
    .cfg_period   (cfg_period),
    .cfg_en       (cfg_en),
    .cfg_periodic (cfg_periodic),
    .evt_valid    (evt_valid),
    .evt_ch       (evt_ch),
    .evt_ready    (evt_ready),
    .ovf          (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [15:0] per,
                           input logic en, input logic pmode);
    cfg_we = 1'b1; cfg_ch = ch; cfg_period = per; cfg_en = en; cfg_periodic = pmode;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_tic();
    tic = 1'b1;
    step();
    tic = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; tic = 1'b0; cfg_we = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (evt_valid !== 1'b0 || evt_ch !== 2'd0 || ovf !== 4'b0000)
      $display("FAIL reset_outputs valid=%b ch=%0d ovf=%b expected 0 0 0000", evt_valid, evt_ch, ovf);
    checks++;
    if (dut.r_last !== 2'd3)
      $display("FAIL reset_last_grant got=%0d expected 3", dut.r_last);
    if (evt_valid !== 1'b0 || evt_ch !== 2'd0 || ovf !== 4'b0000) errors++;
    if (dut.r_last !== 2'd3) errors++;
  endtask

  task automatic test_periodic();
    logic exp_v;
    do_reset();
    evt_ready = 1'b1;
    cfg_write(2'd0, 16'd3, 1'b1, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      pulse_tic();
      checks++;
      if (evt_valid !== 1'b0) begin
        errors++;
        $display("FAIL periodic_t1_tic%0d valid=%b expected 0", k, evt_valid);
      end
      step();
      exp_v = (k % 3 == 0);
      checks++;
      if (evt_valid !== exp_v || (exp_v && evt_ch !== 2'd0)) begin
        errors++;
        $display("FAIL periodic_t2_tic%0d valid=%b ch=%0d expected valid=%b ch=0", k, evt_valid, evt_ch, exp_v);
      end
      repeat (3) step();
    end
    checks++;
    if (ovf !== 4'b0000) begin
      errors++;
      $display("FAIL periodic_ovf got=%b expected 0000", ovf);
    end
  endtask

  task automatic test_oneshot();
    int n_evt;
    do_reset();
    evt_ready = 1'b1;
    n_evt = 0;
    cfg_write(2'd1, 16'd2, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      pulse_tic();
      for (int s = 0; s < 4; s++) begin
        if (evt_valid === 1'b1 && evt_ch === 2'd1) n_evt++;
        step();
      end
    end
    checks++;
    if (n_evt !== 1) begin
      errors++;
      $display("FAIL oneshot_count events=%0d expected 1", n_evt);
    end
    checks++;
    if (dut.r_flags[1].en !== 1'b0 || dut.r_count[1] !== 16'd0) begin
      errors++;
      $display("FAIL oneshot_state en=%b count=%0d expected en=0 count=0", dut.r_flags[1].en, dut.r_count[1]);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] seq [8];
    int n;
    do_reset();
    evt_ready = 1'b1;
    for (int c = 0; c < 4; c++) cfg_write(2'(c), 16'd1, 1'b1, 1'b1);
    for (int r = 0; r < 2; r++) begin
      n = 0;
      pulse_tic();
      for (int s = 0; s < 12; s++) begin
        step();
        if (evt_valid === 1'b1) begin
          if (n < 8) seq[n] = evt_ch;
          n++;
        end
      end
      checks++;
      if (n !== 4) begin
        errors++;
        $display("FAIL rr_round%0d_count events=%0d expected 4", r, n);
      end
      for (int i = 0; i < 4 && i < n; i++) begin
        checks++;
        if (seq[i] !== 2'(i)) begin
          errors++;
          $display("FAIL rr_round%0d_order idx=%0d ch=%0d expected %0d", r, i, seq[i], i);
        end
      end
    end
  endtask

  task automatic test_overrun();
    do_reset();
    evt_ready = 1'b0;
    cfg_write(2'd2, 16'd1, 1'b1, 1'b1);
    pulse_tic();
    step();
    checks++;
    if (evt_valid !== 1'b1 || evt_ch !== 2'd2 || dut.r_flags[2].pending !== 1'b0) begin
      errors++;
      $display("FAIL ovr_first valid=%b ch=%0d pend=%b expected 1 2 0", evt_valid, evt_ch, dut.r_flags[2].pending);
    end
    repeat (2) step();
    pulse_tic();
    checks++;
    if (evt_valid !== 1'b1 || evt_ch !== 2'd2 || dut.r_flags[2].pending !== 1'b1 || ovf !== 4'b0000) begin
      errors++;
      $display("FAIL ovr_second valid=%b ch=%0d pend=%b ovf=%b expected 1 2 1 0000", evt_valid, evt_ch, dut.r_flags[2].pending, ovf);
    end
    step();
    pulse_tic();
    checks++;
    if (evt_valid !== 1'b1 || evt_ch !== 2'd2 || ovf !== 4'b0100) begin
      errors++;
      $display("FAIL ovr_third valid=%b ch=%0d ovf=%b expected 1 2 0100", evt_valid, evt_ch, ovf);
    end
    cfg_write(2'd2, 16'd1, 1'b1, 1'b1);
    checks++;
    if (ovf !== 4'b0000 || evt_valid !== 1'b1 || evt_ch !== 2'd2) begin
      errors++;
      $display("FAIL ovr_cfg_clear ovf=%b valid=%b ch=%0d expected 0000 1 2", ovf, evt_valid, evt_ch);
    end
    evt_ready = 1'b1;
    step();
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovr_accept valid=%b expected 0", evt_valid);
    end
  endtask

  task automatic test_cfg_tic_collision();
    do_reset();
    evt_ready = 1'b1;
    cfg_write(2'd0, 16'd4, 1'b1, 1'b1);
    cfg_write(2'd3, 16'd5, 1'b1, 1'b1);
    cfg_we = 1'b1; cfg_ch = 2'd3; cfg_period = 16'd2; cfg_en = 1'b1; cfg_periodic = 1'b1;
    tic = 1'b1;
    step();
    cfg_we = 1'b0; tic = 1'b0;
    checks++;
    if (dut.r_count[3] !== 16'd2 || dut.r_count[0] !== 16'd3) begin
      errors++;
      $display("FAIL collide_counts ch3=%0d ch0=%0d expected 2 3", dut.r_count[3], dut.r_count[0]);
    end
    pulse_tic();
    step();
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL collide_early valid=%b expected 0", evt_valid);
    end
    pulse_tic();
    step();
    checks++;
    if (evt_valid !== 1'b1 || evt_ch !== 2'd3) begin
      errors++;
      $display("FAIL collide_event valid=%b ch=%0d expected 1 3", evt_valid, evt_ch);
    end
  endtask

  task automatic test_reset_in_hold();
    logic [3:0] ens;
    logic [3:0] pends;
    do_reset();
    evt_ready = 1'b0;
    cfg_write(2'd1, 16'd1, 1'b1, 1'b1);
    cfg_write(2'd2, 16'd1, 1'b1, 1'b1);
    pulse_tic();
    step();
    pulse_tic();
    checks++;
    if (evt_valid !== 1'b1 || evt_ch !== 2'd1 || ovf !== 4'b0100) begin
      errors++;
      $display("FAIL rsthold_setup valid=%b ch=%0d ovf=%b expected 1 1 0100", evt_valid, evt_ch, ovf);
    end
    rst = 1'b1; tic = 1'b1; evt_ready = 1'b1;
    step();
    rst = 1'b0; tic = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ens[i]   = dut.r_flags[i].en;
      pends[i] = dut.r_flags[i].pending;
    end
    checks++;
    if (evt_valid !== 1'b0 || ovf !== 4'b0000 || ens !== 4'b0000 || pends !== 4'b0000) begin
      errors++;
      $display("FAIL rsthold_clear valid=%b ovf=%b en=%b pend=%b expected 0 0000 0000 0000", evt_valid, ovf, ens, pends);
    end
    cfg_write(2'd3, 16'd1, 1'b1, 1'b1);
    cfg_write(2'd0, 16'd1, 1'b1, 1'b1);
    pulse_tic();
    step();
    checks++;
    if (evt_valid !== 1'b1 || evt_ch !== 2'd0) begin
      errors++;
      $display("FAIL rsthold_first_grant valid=%b ch=%0d expected 1 0", evt_valid, evt_ch);
    end
  endtask

  initial begin
    rst = 1'b1; tic = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0;
    cfg_en = 1'b0; cfg_periodic = 1'b0; evt_ready = 1'b0;
    test_reset();
    test_periodic();
    test_oneshot();
    test_round_robin();
    test_overrun();
    test_cfg_tic_collision();
    test_reset_in_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
